// File: rtl/accumulate_ctrl.sv
// Per-layer sequencer for the accumulate datapath: bias fetch, psum streaming,
// accumulator drain and hand-off of each finished output sum.
module accumulate_ctrl #(
  parameter int CH_W  = 8,
  parameter int OUT_W = 10
) (
  input  logic             clk_i,
  input  logic             rst,
  input  logic             start_i,
  input  logic             layer_i,
  input  logic [CH_W-1:0]  n_ch_i,
  input  logic [OUT_W-1:0] n_out_i,
  input  logic [1:0]       fc_lanes_i,
  input  logic             psum_valid_i,
  output logic             psum_ready_o,
  output logic             bias_req_o,
  input  logic             bias_ack_i,
  output logic             acc_en_o,
  output logic [2:0]       acc_flag_o,
  output logic             acc_layer_o,
  input  logic             acc_done_i,
  output logic             out_valid_o,
  input  logic             out_ready_i,
  output logic [OUT_W-1:0] out_idx_o,
  output logic             busy_o,
  output logic             done_o
);

  // Handshakes: a psum beat moves when psum_valid_i & psum_ready_o are high on
  // a rising edge; an output moves when out_valid_o & out_ready_i are high;
  // bias_req_o is held until bias_ack_i. Valid/req never drop before transfer.

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_BIAS  = 3'd1,
    S_ACCUM = 3'd2,
    S_DRAIN = 3'd3,
    S_OUT   = 3'd4,
    S_FIN   = 3'd5
  } state_t;

  state_t state;
  state_t state_next;

  logic             layer_q;
  logic [1:0]       lanes_q;
  logic [CH_W-1:0]  n_ch_q;
  logic [OUT_W-1:0] n_out_q;
  logic [CH_W-1:0]  beat_cnt;
  logic [OUT_W-1:0] out_idx;

  logic       beat_xfer;
  logic       last_beat;
  logic       last_out;
  logic [2:0] lane_mask;

  assign beat_xfer = (state == S_ACCUM) && psum_valid_i;
  assign last_beat = (beat_cnt == (n_ch_q - CH_W'(1)));
  assign last_out  = (out_idx == (n_out_q - OUT_W'(1)));

  // FC lane count of 0 behaves as a single lane; CONV always uses all three.
  always_comb begin
    lane_mask = 3'b111;
    if (layer_q) begin
      case (lanes_q)
        2'd2:    lane_mask = 3'b011;
        2'd3:    lane_mask = 3'b111;
        default: lane_mask = 3'b001;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst) begin
      state <= S_IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst) begin
      layer_q  <= 1'b0;
      lanes_q  <= 2'd0;
      n_ch_q   <= '0;
      n_out_q  <= '0;
      beat_cnt <= '0;
      out_idx  <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start_i) begin
            layer_q <= layer_i;
            lanes_q <= fc_lanes_i;
            n_ch_q  <= (n_ch_i == '0) ? CH_W'(1) : n_ch_i;
            n_out_q <= n_out_i;
            out_idx <= '0;
          end
        end
        S_BIAS: begin
          if (bias_ack_i) begin
            beat_cnt <= '0;
          end
        end
        S_ACCUM: begin
          if (beat_xfer) begin
            beat_cnt <= beat_cnt + CH_W'(1);
          end
        end
        S_OUT: begin
          if (out_ready_i && !last_out) begin
            out_idx <= out_idx + OUT_W'(1);
          end
        end
        default: begin
        end
      endcase
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      S_IDLE: begin
        if (start_i) begin
          state_next = (n_out_i == '0) ? S_FIN : S_BIAS;
        end
      end
      S_BIAS: begin
        if (bias_ack_i) begin
          state_next = S_ACCUM;
        end
      end
      S_ACCUM: begin
        if (beat_xfer && last_beat) begin
          state_next = S_DRAIN;
        end
      end
      S_DRAIN: begin
        if (acc_done_i) begin
          state_next = S_OUT;
        end
      end
      S_OUT: begin
        if (out_ready_i) begin
          state_next = last_out ? S_FIN : S_BIAS;
        end
      end
      S_FIN: begin
        state_next = S_IDLE;
      end
      default: begin
        state_next = S_IDLE;
      end
    endcase
  end

  always_comb begin
    psum_ready_o = 1'b0;
    bias_req_o   = 1'b0;
    acc_en_o     = 1'b0;
    acc_flag_o   = 3'b000;
    out_valid_o  = 1'b0;
    busy_o       = (state != S_IDLE);
    done_o       = 1'b0;
    case (state)
      S_BIAS:  bias_req_o = 1'b1;
      S_ACCUM: begin
        psum_ready_o = 1'b1;
        acc_en_o     = psum_valid_i;
        acc_flag_o   = lane_mask;
      end
      S_OUT:   out_valid_o = 1'b1;
      S_FIN:   done_o = 1'b1;
      default: begin
      end
    endcase
  end

  assign acc_layer_o = layer_q;
  assign out_idx_o   = out_idx;

endmodule

// File: tb/tb_accumulate_ctrl.sv
// Directed bench for accumulate_ctrl: drives whole layers through a reactive
// responder and scores output indices, beat counts, lane masks and done pulses.
module tb_accumulate_ctrl;

  localparam int CH_W  = 8;
  localparam int OUT_W = 10;

  logic             clk_i = 1'b0;
  logic             rst = 1'b1;
  logic             start_i = 1'b0;
  logic             layer_i = 1'b0;
  logic [CH_W-1:0]  n_ch_i = '0;
  logic [OUT_W-1:0] n_out_i = '0;
  logic [1:0]       fc_lanes_i = '0;
  logic             psum_valid_i = 1'b0;
  logic             psum_ready_o;
  logic             bias_req_o;
  logic             bias_ack_i = 1'b0;
  logic             acc_en_o;
  logic [2:0]       acc_flag_o;
  logic             acc_layer_o;
  logic             acc_done_i = 1'b0;
  logic             out_valid_o;
  logic             out_ready_i = 1'b0;
  logic [OUT_W-1:0] out_idx_o;
  logic             busy_o;
  logic             done_o;

  accumulate_ctrl #(.CH_W(CH_W), .OUT_W(OUT_W)) dut (
    .clk_i(clk_i), .rst(rst), .start_i(start_i), .layer_i(layer_i),
    .n_ch_i(n_ch_i), .n_out_i(n_out_i), .fc_lanes_i(fc_lanes_i),
    .psum_valid_i(psum_valid_i), .psum_ready_o(psum_ready_o),
    .bias_req_o(bias_req_o), .bias_ack_i(bias_ack_i),
    .acc_en_o(acc_en_o), .acc_flag_o(acc_flag_o), .acc_layer_o(acc_layer_o),
    .acc_done_i(acc_done_i), .out_valid_o(out_valid_o), .out_ready_i(out_ready_i),
    .out_idx_o(out_idx_o), .busy_o(busy_o), .done_o(done_o)
  );

  // clock / reset
  always #5 clk_i = ~clk_i;

  // scoreboard state
  logic [OUT_W-1:0] exp_q[$];
  int compared   = 0;
  int mismatched = 0;
  logic [2:0] exp_flag  = 3'b000;
  logic       exp_layer = 1'b0;
  int acc_en_cnt, bias_cnt, out_cnt, done_cnt, en_no_valid, overlap;
  int run_len, last_run;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic clear_counts();
    acc_en_cnt = 0; bias_cnt = 0; out_cnt = 0; done_cnt = 0;
    en_no_valid = 0; overlap = 0; run_len = 0; last_run = 0;
  endtask

  function automatic logic [2:0] lane_mask(input logic layer, input int lanes);
    if (!layer) return 3'b111;
    if (lanes == 2) return 3'b011;
    if (lanes == 3) return 3'b111;
    return 3'b001;
  endfunction

  // monitor: samples on the falling edge, away from the active edge
  always @(negedge clk_i) begin
    if (!rst) begin
      if (acc_en_o) begin
        acc_en_cnt++;
        if (!psum_valid_i) en_no_valid++;
        check("acc_flag", 32'(acc_flag_o), 32'(exp_flag));
        check("acc_layer", 32'(acc_layer_o), 32'(exp_layer));
      end
      if (bias_req_o && bias_ack_i) bias_cnt++;
      if (bias_req_o && out_valid_o) overlap++;
      if (done_o) done_cnt++;
      if (out_valid_o) begin
        run_len++;
        if (exp_q.size() == 0) begin
          check("out_extra", 32'(out_idx_o), 32'hFFFF_FFFF);
        end else begin
          check("out_idx", 32'(out_idx_o), 32'(exp_q[0]));
          if (out_ready_i) begin
            void'(exp_q.pop_front());
            out_cnt++;
            last_run = run_len;
            run_len = 0;
          end
        end
      end
    end
  end

  function automatic logic [19:0] all_outputs();
    return {psum_ready_o, bias_req_o, acc_en_o, acc_flag_o, acc_layer_o,
            out_valid_o, out_idx_o, busy_o, done_o};
  endfunction

  // Runs one layer with a reactive responder. vmode 1 toggles psum_valid in
  // ACCUM; stall holds out_ready low that many cycles; spam pulses start_i and
  // acc_done_i where they must be ignored; rst_at >= 0 resets after that many beats.
  task automatic run_layer(input logic layer, input int n_ch, input int n_out,
                           input int lanes, input int vmode, input int stall,
                           input bit spam, input int rst_at);
    int  hold = 0;
    bit  tog = 1'b1;
    bit  seen = 1'b0;
    bit  ended = 1'b0;
    int  done_lat = -1;
    int  eff_ch = (n_ch == 0) ? 1 : n_ch;
    clear_counts();
    exp_flag  = lane_mask(layer, lanes);
    exp_layer = layer;
    if (rst_at < 0) begin
      for (int i = 0; i < n_out; i++) exp_q.push_back(OUT_W'(i));
    end
    @(posedge clk_i); #1;
    layer_i = layer; n_ch_i = CH_W'(n_ch); n_out_i = OUT_W'(n_out);
    fc_lanes_i = 2'(lanes); start_i = 1'b1;
    for (int c = 0; c < 3000; c++) begin
      @(posedge clk_i); #1;
      start_i = spam ? busy_o : 1'b0;
      if (rst_at >= 0 && psum_ready_o && acc_en_cnt == rst_at) begin
        rst = 1'b1; psum_valid_i = 1'b0; bias_ack_i = 1'b0;
        acc_done_i = 1'b0; out_ready_i = 1'b0; start_i = 1'b0;
        @(posedge clk_i); #1;
        check("rst_outputs", 32'(all_outputs()), 32'h0);
        rst = 1'b0;
        repeat (4) @(posedge clk_i);
        #1;
        check("rst_no_done", 32'(done_cnt), 32'd0);
        check("rst_idle", 32'(busy_o), 32'd0);
        return;
      end
      if (done_o && done_lat < 0) done_lat = c + 1;
      bias_ack_i = bias_req_o;
      if (vmode == 1) begin
        if (psum_ready_o) begin psum_valid_i = tog; tog = !tog; end
        else psum_valid_i = 1'b0;
      end else begin
        psum_valid_i = 1'b1;
      end
      acc_done_i = (busy_o && !psum_ready_o && !bias_req_o && !out_valid_o && !done_o)
                   || (spam && psum_ready_o);
      if (out_valid_o) begin
        if (hold < stall) begin out_ready_i = 1'b0; hold++; end
        else begin out_ready_i = 1'b1; hold = 0; end
      end else begin
        out_ready_i = 1'b0;
      end
      if (busy_o) seen = 1'b1;
      else if (seen) begin ended = 1'b1; break; end
    end
    start_i = 1'b0; bias_ack_i = 1'b0; psum_valid_i = 1'b0;
    acc_done_i = 1'b0; out_ready_i = 1'b0;
    @(negedge clk_i);
    check("layer_end", 32'(ended), 32'd1);
    check("bias_cnt", 32'(bias_cnt), 32'(n_out));
    check("acc_en_cnt", 32'(acc_en_cnt), 32'(n_out * eff_ch));
    check("out_cnt", 32'(out_cnt), 32'(n_out));
    check("done_cnt", 32'(done_cnt), 32'd1);
    check("en_no_valid", 32'(en_no_valid), 32'd0);
    check("bias_out_overlap", 32'(overlap), 32'd0);
    check("queue_empty", 32'(exp_q.size()), 32'd0);
    check("layer_held", 32'(acc_layer_o), 32'(layer));
    check("idx_held", 32'(out_idx_o), (n_out == 0) ? 32'd0 : 32'(n_out - 1));
    if (n_out == 0) check("empty_done_lat", 32'(done_lat >= 1 && done_lat <= 2), 32'd1);
    if (stall > 0) check("out_hold_len", 32'(last_run), 32'(stall + 1));
    exp_q.delete();
  endtask

  initial begin
    clear_counts();
    repeat (3) @(posedge clk_i);
    #1;
    check("reset_outputs", 32'(all_outputs()), 32'h0);
    rst = 1'b0;
    // 1: CONV, n_ch=4, n_out=2, everything ready
    run_layer(1'b0, 4, 2, 0, 0, 0, 1'b0, -1);
    // 2: FC, 2 lanes, n_ch=3, toggling psum_valid
    run_layer(1'b1, 3, 1, 2, 1, 0, 1'b0, -1);
    // 3: empty layer
    run_layer(1'b0, 4, 0, 0, 0, 0, 1'b0, -1);
    // 4: output writer stalls 5 cycles per output
    run_layer(1'b0, 2, 2, 0, 0, 5, 1'b0, -1);
    // 5: reset mid-ACCUM, then a clean rerun
    run_layer(1'b0, 4, 2, 0, 0, 0, 1'b0, 2);
    run_layer(1'b0, 4, 2, 0, 0, 0, 1'b0, -1);
    // 6: start_i and acc_done_i pulsed where they must be ignored
    run_layer(1'b0, 4, 2, 0, 0, 0, 1'b1, -1);
    // n_ch=0 and fc_lanes=0 both behave as 1
    run_layer(1'b1, 0, 3, 0, 1, 1, 1'b0, -1);
    // random-sized FC layer with 3 lanes
    run_layer(1'b1, $urandom_range(1, 6), $urandom_range(1, 4), 3, 1, $urandom_range(0, 2), 1'b0, -1);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
